noise_gen_multi: RTL and testbench
==================================

# noise_gen_multi

Multi-channel, parametrised LFSR noise source for the I2S synth voice path. It is the next generation of the single-channel free-running LFSR noise block. It provides N independent 32-bit Galois LFSRs and a per-sample processing sequencer with four noise colours/modes. Amplitude is scaled digitally, and results are delivered as a parallel frame with a valid strobe aligned to the audio sample clock. It sits between the sample-rate strobe generator and the voice mixer.

## Interface
- WIDTH, 16: output sample width, signed two's complement; legal 8..32.
- CHANNELS, 4: number of independent noise channels; legal 1..8.
- SEED, 32'hABABABAB: base LFSR seed; must be nonzero.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- sample_stb  in  1  one-cycle pulse per audio sample; starts a frame.
- mode  in  2  0 white, 1 sample-and-hold, 2 red (low-pass), 3 binary.
- rate_div  in  8  sample-and-hold period minus 1, in frames.
- level  in  9  amplitude; 256 = unity; values above 256 are treated as 256.
- audio_out  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  one-cycle pulse when the audio_out frame is updated.
- busy  out  1  high while the frame sequencer is running.
- overrun  out  1  sticky flag: sample_stb arrived while busy; cleared only by reset.

## Operation
- **LFSRs**
  - Polynomial x^32+x^22+x^2+x+1, right-shift Galois form: next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - Each channel's LFSR steps every clk, free-running, independent of sample_stb.
  - Channel k seed = SEED rotated left by (5*k mod 32).
  - A state of all zeros is detected and reloaded with that channel's seed on the next clk.
- **Raw sample:** r_k = lfsr_k[31 -: WIDTH], captured for all channels at the cycle sample_stb is accepted.
- **Frame latch:** mode, rate_div and level are latched at acceptance. Input changes mid-frame do not affect the current frame.
- **Sequencer FSM**
  - IDLE: on sample_stb go to RUN with ch=0 and assert busy.
  - RUN: process one channel per cycle, ch incrementing 0..CHANNELS-1. After the last channel go to DONE.
  - DONE: write all results to audio_out together, pulse out_valid for one cycle, deassert busy, return to IDLE.
  - A shared multiplier is time-multiplexed across channels.
- **Modes** (x_k is the pre-scale value):
  - 0, white: x = r.
  - 1, sample-and-hold: per-channel hold_cnt.
    - hold_cnt == 0: x = r and hold_cnt <= rate_div.
    - Otherwise: x = previous x and hold_cnt decrements.
  - 2, red: per-channel state y <= y + ((r − y) >>> 3), computed in WIDTH+1 bits, arithmetic shift, result truncated to WIDTH. It cannot overflow because the result lies between y and r. x = y.
  - 3, binary: x = r[MSB] ? −(2^(WIDTH−1)−1) : +(2^(WIDTH−1)−1).
- **State across mode switches:** y and hold_cnt persist. A switch takes effect on the next frame with no reset of state.
- **Scaling:** out = (x * min(level,256)) >>> 8, signed, WIDTH+9-bit product, truncated to WIDTH. level=0 gives 0; level=256 gives x exactly.

## Timing
- **Reset values:**
  - LFSRs at their seeds; audio_out, y and hold_cnt all 0.
  - FSM IDLE; out_valid, busy and overrun all 0.
- **Latency:** sample_stb accepted at cycle t; out_valid high and audio_out updated at cycle t+CHANNELS+1. busy is high for cycles t+1..t+CHANNELS.
- **Hold:** audio_out holds its value between out_valid pulses.
- **Minimum strobe spacing:** CHANNELS+2 cycles.
- **Overrun:** sample_stb while busy, or in the DONE cycle, is ignored and sets overrun. The frame in progress completes normally.
- **Reset mid-frame:** asynchronous. All outputs take their reset values immediately, and no out_valid is produced for the aborted frame.
- **sample_stb held high:** each cycle it is high counts as a strobe. The first is accepted; later ones set overrun.

## Test plan
- WIDTH=16, CHANNELS=4: reset, then sample_stb at cycle 10 -> busy high for cycles 11–14; out_valid only at cycle 15; reset values all 0 before that.
- mode=3, level=256 -> every channel is exactly +32767 or −32767, matching r[15] from a reference LFSR model per channel seed. level=0 -> all channels 0.
- mode=0, level=128 -> each channel equals (r*128)>>>8 of its own seeded LFSR. Channel values are pairwise different.
- mode=1, rate_div=3, strobes every 20 cycles -> each channel's output changes only on frames 0, 4, 8, ….
- Second sample_stb 2 cycles after the first -> ignored, overrun=1 and stays set; that frame's out_valid still occurs at t+5.
- reset asserted at t+2 of a frame -> no out_valid; busy=0 immediately. The next strobe after release yields output identical to the first post-reset frame at the same LFSR phase.

Source files
------------

// File: rtl/noise_gen_multi.sv
// Multi-channel Galois LFSR noise source with a per-sample channel sequencer,
// four noise modes and a shared amplitude multiplier.
module noise_gen_multi #(
   parameter int          WIDTH    = 16,
   parameter int          CHANNELS = 4,
   parameter logic [31:0] SEED     = 32'hABABABAB
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sample_stb,
   input  logic [1:0]                   mode,
   input  logic [7:0]                   rate_div,
   input  logic [8:0]                   level,
   output logic [CHANNELS*WIDTH-1:0]    audio_out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         overrun
);

   localparam int                      CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [31:0]             POLY = 32'h80200003;
   localparam logic signed [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   function automatic logic [31:0] f_seed(input int k);
      logic [31:0] s;
      s = SEED;
      for (int i = 0; i < (5 * k) % 32; i++) s = {s[30:0], s[31]};
      return s;
   endfunction

   function automatic logic [31:0] f_lfsr(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? POLY : 32'h0);
   endfunction

   // One-pole low-pass step; the result lies between y and r so truncation is safe.
   function automatic logic signed [WIDTH-1:0] f_red(input logic signed [WIDTH-1:0] r,
                                                     input logic signed [WIDTH-1:0] y);
      logic signed [WIDTH:0] d;
      logic signed [WIDTH:0] s;
      d = (WIDTH+1)'(r) - (WIDTH+1)'(y);
      s = (WIDTH+1)'(y) + (d >>> 3);
      return WIDTH'(s);
   endfunction

   function automatic logic signed [WIDTH-1:0] f_bin(input logic neg);
      return neg ? -MAXP : MAXP;
   endfunction

   function automatic logic signed [WIDTH-1:0] f_scale(input logic signed [WIDTH-1:0] x,
                                                       input logic [8:0] lvl);
      logic signed [WIDTH+8:0] p;
      p = (WIDTH+9)'(x) * (WIDTH+9)'($signed({1'b0, lvl}));
      return WIDTH'(p >>> 8);
   endfunction

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_ch;
   logic                    r_overrun;
   logic [31:0]             r_lfsr  [CHANNELS];
   logic signed [WIDTH-1:0] r_raw   [CHANNELS];
   logic signed [WIDTH-1:0] r_y     [CHANNELS];
   logic signed [WIDTH-1:0] r_xprev [CHANNELS];
   logic signed [WIDTH-1:0] r_res   [CHANNELS];
   logic [7:0]              r_hold  [CHANNELS];
   logic [1:0]              r_mode;
   logic [7:0]              r_rate;
   logic [8:0]              r_lvl;
   logic [CHANNELS*WIDTH-1:0] r_audio;

   logic                    w_accept;
   logic                    w_last;
   logic signed [WIDTH-1:0] w_r, w_x, w_y_nxt, w_scaled;
   logic [7:0]              w_hold_nxt;

   assign w_accept  = (r_state == S_IDLE) && sample_stb;
   assign w_last    = (r_ch == CW'(CHANNELS - 1));
   assign audio_out = r_audio;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_RUN);
   assign overrun   = r_overrun;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (sample_stb) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)     w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ch      <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_accept)                        r_ch <= '0;
         else if (r_state == S_RUN && !w_last) r_ch <= r_ch + CW'(1);
         if (sample_stb && r_state != S_IDLE) r_overrun <= 1'b1;
      end
   end

   // Free-running LFSRs, self-healing from the lock-up state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) r_lfsr[k] <= f_seed(k);
      end else begin
         for (int k = 0; k < CHANNELS; k++)
            r_lfsr[k] <= (r_lfsr[k] == 32'h0) ? f_seed(k) : f_lfsr(r_lfsr[k]);
      end
   end

   // Stage p0: per-channel mode processing on the channel selected by r_ch.
   always_comb begin
      w_r        = r_raw[r_ch];
      w_x        = w_r;
      w_y_nxt    = r_y[r_ch];
      w_hold_nxt = r_hold[r_ch];
      case (r_mode)
         2'd1: begin
            if (r_hold[r_ch] == 8'd0) begin
               w_x        = w_r;
               w_hold_nxt = r_rate;
            end else begin
               w_x        = r_xprev[r_ch];
               w_hold_nxt = r_hold[r_ch] - 8'd1;
            end
         end
         2'd2: begin
            w_y_nxt = f_red(w_r, r_y[r_ch]);
            w_x     = w_y_nxt;
         end
         2'd3:    w_x = f_bin(w_r[WIDTH-1]);
         default: w_x = w_r;
      endcase
      w_scaled = f_scale(w_x, r_lvl);
   end

   // Stage p1: frame capture, per-channel state update and frame publication.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < CHANNELS; k++) begin
            r_raw[k]   <= '0;
            r_y[k]     <= '0;
            r_xprev[k] <= '0;
            r_res[k]   <= '0;
            r_hold[k]  <= '0;
         end
         r_mode  <= '0;
         r_rate  <= '0;
         r_lvl   <= '0;
         r_audio <= '0;
      end else begin
         if (w_accept) begin
            for (int k = 0; k < CHANNELS; k++) r_raw[k] <= r_lfsr[k][31 -: WIDTH];
            r_mode <= mode;
            r_rate <= rate_div;
            r_lvl  <= (level > 9'd256) ? 9'd256 : level;
         end
         if (r_state == S_RUN) begin
            for (int k = 0; k < CHANNELS; k++) begin
               if (CW'(k) == r_ch) begin
                  r_y[k]     <= w_y_nxt;
                  r_hold[k]  <= w_hold_nxt;
                  r_xprev[k] <= w_x;
                  r_res[k]   <= w_scaled;
               end
            end
            if (w_last) begin
               for (int k = 0; k < CHANNELS; k++)
                  r_audio[k*WIDTH +: WIDTH] <= (CW'(k) == r_ch) ? w_scaled : r_res[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_noise_gen_multi.sv
// Bench for noise_gen_multi: reference LFSR/mode model feeding a scoreboard queue,
// a table of mode/level vectors and hand sequences for timing, hold, overrun and reset.
module tb_noise_gen_multi;

   localparam int          W    = 16;
   localparam int          N    = 4;
   localparam logic [31:0] SEED = 32'hABABABAB;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           sample_stb = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [7:0]     rate_div = 8'd0;
   logic [8:0]     level = 9'd0;
   logic [N*W-1:0] audio_out;
   logic           out_valid, busy, overrun;

   int tests = 0;
   int fails = 0;
   int expq[$];
   logic [N*W-1:0] last_out = '0;
   logic [31:0] m_lfsr [N];
   int m_y [N];
   int m_hold [N];
   int m_xprev [N];

   typedef struct {
      int mode;
      int rate;
      int lvl;
      int exp_abs;
      bit distinct;
   } vec_t;
   vec_t tbl [10];

   noise_gen_multi #(.WIDTH(W), .CHANNELS(N), .SEED(SEED)) dut (
      .clk(clk), .reset(rst), .sample_stb(sample_stb), .mode(mode),
      .rate_div(rate_div), .level(level), .audio_out(audio_out),
      .out_valid(out_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] seed_of(input int k);
      logic [63:0] t;
      t = {SEED, SEED} << ((5 * k) % 32);
      return t[63:32];
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < N; k++) begin
         if (rst) m_lfsr[k] <= seed_of(k);
         else     m_lfsr[k] <= (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 32'h80200003 : 32'h0);
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   function automatic int chan(input logic [N*W-1:0] v, input int k);
      return int'($signed(v[k*W +: W]));
   endfunction

   function automatic void push_frame(input int md, input int rt, input int lv);
      int l;
      l = (lv > 256) ? 256 : lv;
      for (int k = 0; k < N; k++) begin
         int r, x;
         r = int'($signed(m_lfsr[k][31:16]));
         case (md)
            0: x = r;
            1: begin
               if (m_hold[k] == 0) begin x = r; m_hold[k] = rt; end
               else begin x = m_xprev[k]; m_hold[k] = m_hold[k] - 1; end
            end
            2: begin m_y[k] = m_y[k] + ((r - m_y[k]) >>> 3); x = m_y[k]; end
            default: x = (r < 0) ? -32767 : 32767;
         endcase
         m_xprev[k] = x;
         expq.push_back((x * l) >>> 8);
      end
   endfunction

   always @(negedge clk) begin
      if (out_valid) begin
         chk("frame_expected", expq.size(), N);
         if (expq.size() >= N) begin
            for (int k = 0; k < N; k++) begin
               int e;
               e = expq.pop_front();
               chk($sformatf("ch%0d_data", k), chan(audio_out, k), e);
            end
         end
         last_out = audio_out;
      end
   end

   task automatic clear_model();
      expq.delete();
      for (int k = 0; k < N; k++) begin
         m_y[k] = 0; m_hold[k] = 0; m_xprev[k] = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_model();
   endtask

   // Strobe a frame, check busy/out_valid on every following cycle, and scramble
   // the inputs right after acceptance; extra>0 raises a stray strobe at t+extra.
   task automatic timed_frame(input int md, input int rt, input int lv, input int extra);
      @(negedge clk);
      mode = 2'(md); rate_div = 8'(rt); level = 9'(lv); sample_stb = 1'b1;
      push_frame(md, rt, lv);
      for (int i = 1; i <= N + 2; i++) begin
         @(negedge clk);
         chk($sformatf("busy_t+%0d", i), int'(busy), (i <= N) ? 1 : 0);
         chk($sformatf("valid_t+%0d", i), int'(out_valid), (i == N + 1) ? 1 : 0);
         sample_stb = (i == extra);
         if (i == 1) begin
            mode = ~mode; level = 9'($urandom_range(0, 511)); rate_div = 8'($urandom);
         end
      end
   endtask

   initial begin
      logic [N*W-1:0] prev, ref_out;
      tbl[0] = '{3, 0, 256, 32767, 1'b0};
      tbl[1] = '{3, 0,   0,     0, 1'b0};
      tbl[2] = '{0, 0, 128,    -1, 1'b1};
      tbl[3] = '{0, 0, 511,    -1, 1'b1};
      tbl[4] = '{2, 0, 256,    -1, 1'b0};
      tbl[5] = '{2, 0, 256,    -1, 1'b0};
      tbl[6] = '{2, 0, 200,    -1, 1'b0};
      tbl[7] = '{1, 1, 256,    -1, 1'b0};
      tbl[8] = '{3, 0, 300, 32767, 1'b0};
      tbl[9] = '{0, 0, 256,    -1, 1'b0};

      do_reset();
      for (int k = 0; k < N; k++) chk($sformatf("rst_audio_ch%0d", k), chan(audio_out, k), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_overrun", int'(overrun), 0);

      repeat (9) @(negedge clk);
      timed_frame(0, 0, 256, 0);

      // Sample-and-hold, rate_div=3, strobes every 20 cycles.
      prev = last_out;
      for (int f = 0; f < 9; f++) begin
         timed_frame(1, 3, 256, 0);
         repeat (13) @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (f % 4 == 0)
               chk($sformatf("sh_change_f%0d_ch%0d", f, k), int'(chan(last_out, k) != chan(prev, k)), 1);
            else
               chk($sformatf("sh_hold_f%0d_ch%0d", f, k), chan(last_out, k), chan(prev, k));
         end
         prev = last_out;
      end

      for (int i = 0; i < 10; i++) begin
         timed_frame(tbl[i].mode, tbl[i].rate, tbl[i].lvl, 0);
         for (int k = 0; k < N; k++) begin
            int v;
            v = chan(last_out, k);
            if (tbl[i].exp_abs >= 0)
               chk($sformatf("vec%0d_abs_ch%0d", i, k), (v < 0) ? -v : v, tbl[i].exp_abs);
            if (tbl[i].distinct)
               for (int j = k + 1; j < N; j++)
                  chk($sformatf("vec%0d_distinct_%0d_%0d", i, k, j),
                      int'(v != chan(last_out, j)), 1);
         end
      end

      chk("overrun_clear", int'(overrun), 0);
      timed_frame(0, 0, 256, 2);
      chk("overrun_set", int'(overrun), 1);
      timed_frame(3, 0, 256, 0);
      chk("overrun_sticky", int'(overrun), 1);

      // Reference frame at a fixed LFSR phase after reset.
      do_reset();
      chk("overrun_reset", int'(overrun), 0);
      repeat (5) @(negedge clk);
      timed_frame(0, 0, 200, 0);
      ref_out = last_out;

      // Abort a frame with reset at t+2, then repeat the same phase.
      do_reset();
      repeat (5) @(negedge clk);
      @(negedge clk);
      mode = 2'd0; level = 9'd200; sample_stb = 1'b1;
      @(negedge clk);
      sample_stb = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(out_valid), 0);
      for (int k = 0; k < N; k++) chk($sformatf("abort_audio_ch%0d", k), chan(audio_out, k), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_valid", int'(out_valid), 0);
      end
      timed_frame(0, 0, 200, 0);
      for (int k = 0; k < N; k++)
         chk($sformatf("replay_ch%0d", k), chan(last_out, k), chan(ref_out, k));

      chk("queue_drained", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
